// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and small helpers for the 4-to-2 button encoder.
package enc_pkg;

    localparam int NUM_KEYS = 4;
    localparam int CODE_W   = 2;

    // Active-low LED bus with every LED dark.
    localparam logic [NUM_KEYS-1:0] LED_OFF = 4'b1111;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } enc_state_t;

    // Index of the highest pressed key. A later (higher) match overrides an earlier one.
    function automatic logic [CODE_W-1:0] prio_encode(input logic [NUM_KEYS-1:0] pressed);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pressed[i]) begin
                code = CODE_W'(i);
            end
        end
        return code;
    endfunction

    // Active-low one-hot LED pattern for a key index.
    function automatic logic [NUM_KEYS-1:0] led_pattern(input logic [CODE_W-1:0] code);
        return ~(NUM_KEYS'(1) << code);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One key channel: 2-flop synchronizer followed by a saturating stability
// counter that flips the debounced level after DEBOUNCE_CYCLES disagreeing samples.
module debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_raw_n,
    output logic key_level_n
);

    // The counter only ever holds 0..DEBOUNCE_CYCLES-1.
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key into the sys_clk domain; idles at released (1).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_raw_n;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive disagreeing samples; any agreement restarts the count.
    // Reaching the last count flips the level and clears, so the counter never wraps.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt         <= '0;
            key_level_n <= 1'b1;
        end else if (sync_q2 == key_level_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt         <= '0;
            key_level_n <= sync_q2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/button_encoder_4to2.sv
// Four debounced active-low keys encoded to a 2-bit index with a one-cycle
// capture strobe and an active-low one-hot LED display.
// Optional macro ENC_LATCH_EN: when defined, the last captured code, its LED
// pattern and key_valid are held after all keys are released (until reset).
//
// state  | meaning
// IDLE   | no debounced key held; waiting for a press to capture
// LOCKED | a key was captured; code frozen until every key is released
module button_encoder_4to2
    import enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_pulse,
    output logic [NUM_KEYS-1:0] led
);

    logic [NUM_KEYS-1:0] level_n;
    logic [NUM_KEYS-1:0] pressed;
    enc_state_t          state;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .sys_clk    (sys_clk),
            .sys_rst_n  (sys_rst_n),
            .key_raw_n  (key_n[g]),
            .key_level_n(level_n[g])
        );
    end

    assign pressed = ~level_n;

    // Capture on the first press, freeze while locked, unlock when all keys are up.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_pulse <= 1'b0;
            led       <= LED_OFF;
        end else begin
            key_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pressed) begin
                        state     <= LOCKED;
                        key_code  <= prio_encode(pressed);
                        key_valid <= 1'b1;
                        key_pulse <= 1'b1;
                        led       <= led_pattern(prio_encode(pressed));
                    end
                end
                LOCKED: begin
                    if (!(|pressed)) begin
                        state <= IDLE;
`ifdef ENC_LATCH_EN
                        // Keep showing the last key after release.
`else
                        key_code  <= '0;
                        key_valid <= 1'b0;
                        led       <= LED_OFF;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
